pif_pipe_bridge: RTL and testbench

//  Registered, parametrised PIF master-to-slave bridge. Successor to the pass-through PIF loopback.

---
 rtl/pif_bridge_pkg.sv | 19 +
 rtl/pif_bridge_fifo.sv | 60 ++++++
 rtl/pif_pipe_bridge.sv | 167 ++++++++++++++++
 tb/tb_pif_pipe_bridge.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pif_bridge_pkg.sv
// pif_bridge_pkg: shared constants and packed-width helpers for the PIF pipe bridge.
package pif_bridge_pkg;

    localparam int PIF_CNTL_LAST_BIT = 0;
    localparam int PIF_CNTL_W        = 8;
    localparam int PIF_PRIO_W        = 2;

    // Width of one packed request beat: cntl, adrs, data, byte enables, id, priority, attribute, route.
    function automatic int reqWidth(input int addrW, input int dataW, input int idW,
                                    input int attrW, input int routeW);
        return PIF_CNTL_W + addrW + dataW + dataW / 8 + idW + PIF_PRIO_W + attrW + routeW;
    endfunction

    // Width of one packed response beat: cntl, data, id, priority, route.
    function automatic int respWidth(input int dataW, input int idW, input int routeW);
        return PIF_CNTL_W + dataW + idW + PIF_PRIO_W + routeW;
    endfunction

endpackage

// File: rtl/pif_bridge_fifo.sv
// pif_bridge_fifo: synchronous FIFO with wrap-bit pointers and registered full/empty flags.
module pif_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtrNext;
    logic [PW-1:0]    rdPtrNext;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doPush;
    logic             doPop;

    assign doPush    = push && !full;
    assign doPop     = pop && !empty;
    assign wrPtrNext = wrPtr + PW'(doPush);
    assign rdPtrNext = rdPtr + PW'(doPop);
    assign popData   = mem[rdPtr[AW-1:0]];

    // Advance pointers and precompute the flags from the next pointer values so they leave a flop.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wrPtr <= wrPtrNext;
            rdPtr <= rdPtrNext;
            empty <= (wrPtrNext == rdPtrNext);
            full  <= (wrPtrNext[AW] != rdPtrNext[AW]) &&
                     (wrPtrNext[AW-1:0] == rdPtrNext[AW-1:0]);
        end
    end

    // Storage is cleared on reset so the payload outputs read as zero while empty after reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (doPush) begin
            mem[wrPtr[AW-1:0]] <= pushData;
        end
    end

endmodule

// File: rtl/pif_pipe_bridge.sv
// pif_pipe_bridge: registered PIF master-to-slave bridge with request/response FIFOs
// and a per-transaction outstanding limiter.
module pif_pipe_bridge
    import pif_bridge_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int ID_W       = 6,
    parameter int ATTR_W     = 12,
    parameter int ROUTE_W    = 1,
    parameter int REQ_DEPTH  = 4,
    parameter int RESP_DEPTH = 4,
    parameter int MAX_OUT    = 8
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                POReqValid_M,
    output logic                PIReqRdy_M,
    input  logic [7:0]          POReqCntl_M,
    input  logic [ADDR_W-1:0]   POReqAdrs_M,
    input  logic [DATA_W-1:0]   POReqData_M,
    input  logic [DATA_W/8-1:0] POReqDataBE_M,
    input  logic [ID_W-1:0]     POReqId_M,
    input  logic [1:0]          POReqPriority_M,
    input  logic [ATTR_W-1:0]   POReqAttribute_M,
    input  logic [ROUTE_W-1:0]  POReqRouteId_M,
    output logic                PIRespValid_M,
    input  logic                PORespRdy_M,
    output logic [7:0]          PIRespCntl_M,
    output logic [DATA_W-1:0]   PIRespData_M,
    output logic [ID_W-1:0]     PIRespId_M,
    output logic [1:0]          PIRespPriority_M,
    output logic [ROUTE_W-1:0]  PIRespRouteId_M,
    output logic                POReqValid_S,
    input  logic                PIReqRdy_S,
    output logic [7:0]          POReqCntl_S,
    output logic [ADDR_W-1:0]   POReqAdrs_S,
    output logic [DATA_W-1:0]   POReqData_S,
    output logic [DATA_W/8-1:0] POReqDataBE_S,
    output logic [ID_W-1:0]     POReqId_S,
    output logic [1:0]          POReqPriority_S,
    output logic [ATTR_W-1:0]   POReqAttribute_S,
    output logic [ROUTE_W-1:0]  POReqRouteId_S,
    input  logic                PIRespValid_S,
    output logic                PORespRdy_S,
    input  logic [7:0]          PIRespCntl_S,
    input  logic [DATA_W-1:0]   PIRespData_S,
    input  logic [ID_W-1:0]     PIRespId_S,
    input  logic [1:0]          PIRespPriority_S,
    input  logic [ROUTE_W-1:0]  PIRespRouteId_S
);

    localparam int REQ_W  = reqWidth(ADDR_W, DATA_W, ID_W, ATTR_W, ROUTE_W);
    localparam int RESP_W = respWidth(DATA_W, ID_W, ROUTE_W);
    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    typedef struct packed {
        logic [PIF_CNTL_W-1:0] cntl;
        logic [ADDR_W-1:0]     adrs;
        logic [DATA_W-1:0]     data;
        logic [DATA_W/8-1:0]   dataBe;
        logic [ID_W-1:0]       id;
        logic [PIF_PRIO_W-1:0] prio;
        logic [ATTR_W-1:0]     attr;
        logic [ROUTE_W-1:0]    routeId;
    } reqBeat_t;

    typedef struct packed {
        logic [PIF_CNTL_W-1:0] cntl;
        logic [DATA_W-1:0]     data;
        logic [ID_W-1:0]       id;
        logic [PIF_PRIO_W-1:0] prio;
        logic [ROUTE_W-1:0]    routeId;
    } respBeat_t;

    reqBeat_t         reqIn;
    reqBeat_t         reqOut;
    respBeat_t        respIn;
    respBeat_t        respOut;
    logic             reqFull;
    logic             reqEmpty;
    logic             respFull;
    logic             respEmpty;
    logic             reqPush;
    logic             respPop;
    logic             reqLast;
    logic             respLast;
    logic             rstDone;
    logic [CNT_W-1:0] outCnt;
    logic             underflowPulse;

    assign reqIn = '{cntl: POReqCntl_M, adrs: POReqAdrs_M, data: POReqData_M,
                     dataBe: POReqDataBE_M, id: POReqId_M, prio: POReqPriority_M,
                     attr: POReqAttribute_M, routeId: POReqRouteId_M};

    assign respIn = '{cntl: PIRespCntl_S, data: PIRespData_S, id: PIRespId_S,
                      prio: PIRespPriority_S, routeId: PIRespRouteId_S};

    assign PIReqRdy_M    = rstDone && !reqFull && (outCnt != MAX_CNT);
    assign PORespRdy_S   = rstDone && !respFull;
    assign POReqValid_S  = !reqEmpty;
    assign PIRespValid_M = !respEmpty;

    assign reqPush  = POReqValid_M && PIReqRdy_M;
    assign respPop  = PIRespValid_M && PORespRdy_M;
    assign reqLast  = reqPush && POReqCntl_M[PIF_CNTL_LAST_BIT];
    assign respLast = respPop && respOut.cntl[PIF_CNTL_LAST_BIT];

    assign POReqCntl_S      = reqOut.cntl;
    assign POReqAdrs_S      = reqOut.adrs;
    assign POReqData_S      = reqOut.data;
    assign POReqDataBE_S    = reqOut.dataBe;
    assign POReqId_S        = reqOut.id;
    assign POReqPriority_S  = reqOut.prio;
    assign POReqAttribute_S = reqOut.attr;
    assign POReqRouteId_S   = reqOut.routeId;

    assign PIRespCntl_M     = respOut.cntl;
    assign PIRespData_M     = respOut.data;
    assign PIRespId_M       = respOut.id;
    assign PIRespPriority_M = respOut.prio;
    assign PIRespRouteId_M  = respOut.routeId;

    pif_bridge_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) reqFifo (
        .clk(CLK), .rstN(RESET_N),
        .push(reqPush), .pushData(reqIn),
        .pop(POReqValid_S && PIReqRdy_S), .popData(reqOut),
        .full(reqFull), .empty(reqEmpty)
    );

    pif_bridge_fifo #(.WIDTH(RESP_W), .DEPTH(RESP_DEPTH)) respFifo (
        .clk(CLK), .rstN(RESET_N),
        .push(PIRespValid_S && PORespRdy_S), .pushData(respIn),
        .pop(respPop), .popData(respOut),
        .full(respFull), .empty(respEmpty)
    );

    // Hold both ready outputs low until the first clock edge after reset release.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rstDone <= 1'b0;
        end else begin
            rstDone <= 1'b1;
        end
    end

    // Count transactions between the last request beat and the last response beat; underflow saturates.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            outCnt         <= '0;
            underflowPulse <= 1'b0;
        end else begin
            underflowPulse <= 1'b0;
            if (reqLast && !respLast) begin
                outCnt <= outCnt + 1'b1;
            end else if (!reqLast && respLast) begin
                if (outCnt == '0) begin
                    underflowPulse <= 1'b1;
                end else begin
                    outCnt <= outCnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pif_pipe_bridge.sv
// tb_pif_pipe_bridge: directed stimulus with scoreboard queues checked by independent monitors.
module tb_pif_pipe_bridge;

    localparam int BUDGET = 20;

    typedef struct packed {
        logic [7:0]  cntl;
        logic [31:0] adrs;
        logic [63:0] data;
        logic [7:0]  be;
        logic [5:0]  id;
        logic [1:0]  prio;
        logic [11:0] attr;
        logic [0:0]  routeId;
    } reqVec_t;

    typedef struct packed {
        logic [7:0]  cntl;
        logic [63:0] data;
        logic [5:0]  id;
        logic [1:0]  prio;
        logic [0:0]  routeId;
    } respVec_t;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        POReqValid_M;
    logic        PIReqRdy_M;
    logic [7:0]  POReqCntl_M;
    logic [31:0] POReqAdrs_M;
    logic [63:0] POReqData_M;
    logic [7:0]  POReqDataBE_M;
    logic [5:0]  POReqId_M;
    logic [1:0]  POReqPriority_M;
    logic [11:0] POReqAttribute_M;
    logic [0:0]  POReqRouteId_M;
    logic        PIRespValid_M;
    logic        PORespRdy_M;
    logic [7:0]  PIRespCntl_M;
    logic [63:0] PIRespData_M;
    logic [5:0]  PIRespId_M;
    logic [1:0]  PIRespPriority_M;
    logic [0:0]  PIRespRouteId_M;
    logic        POReqValid_S;
    logic        PIReqRdy_S;
    logic [7:0]  POReqCntl_S;
    logic [31:0] POReqAdrs_S;
    logic [63:0] POReqData_S;
    logic [7:0]  POReqDataBE_S;
    logic [5:0]  POReqId_S;
    logic [1:0]  POReqPriority_S;
    logic [11:0] POReqAttribute_S;
    logic [0:0]  POReqRouteId_S;
    logic        PIRespValid_S;
    logic        PORespRdy_S;
    logic [7:0]  PIRespCntl_S;
    logic [63:0] PIRespData_S;
    logic [5:0]  PIRespId_S;
    logic [1:0]  PIRespPriority_S;
    logic [0:0]  PIRespRouteId_S;

    reqVec_t  reqQ[$];
    respVec_t respQ[$];
    int       nCompared   = 0;
    int       nMismatched = 0;

    pif_pipe_bridge #(
        .ADDR_W(32), .DATA_W(64), .ID_W(6), .ATTR_W(12), .ROUTE_W(1),
        .REQ_DEPTH(4), .RESP_DEPTH(4), .MAX_OUT(2)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .POReqValid_M(POReqValid_M), .PIReqRdy_M(PIReqRdy_M),
        .POReqCntl_M(POReqCntl_M), .POReqAdrs_M(POReqAdrs_M), .POReqData_M(POReqData_M),
        .POReqDataBE_M(POReqDataBE_M), .POReqId_M(POReqId_M), .POReqPriority_M(POReqPriority_M),
        .POReqAttribute_M(POReqAttribute_M), .POReqRouteId_M(POReqRouteId_M),
        .PIRespValid_M(PIRespValid_M), .PORespRdy_M(PORespRdy_M),
        .PIRespCntl_M(PIRespCntl_M), .PIRespData_M(PIRespData_M), .PIRespId_M(PIRespId_M),
        .PIRespPriority_M(PIRespPriority_M), .PIRespRouteId_M(PIRespRouteId_M),
        .POReqValid_S(POReqValid_S), .PIReqRdy_S(PIReqRdy_S),
        .POReqCntl_S(POReqCntl_S), .POReqAdrs_S(POReqAdrs_S), .POReqData_S(POReqData_S),
        .POReqDataBE_S(POReqDataBE_S), .POReqId_S(POReqId_S), .POReqPriority_S(POReqPriority_S),
        .POReqAttribute_S(POReqAttribute_S), .POReqRouteId_S(POReqRouteId_S),
        .PIRespValid_S(PIRespValid_S), .PORespRdy_S(PORespRdy_S),
        .PIRespCntl_S(PIRespCntl_S), .PIRespData_S(PIRespData_S), .PIRespId_S(PIRespId_S),
        .PIRespPriority_S(PIRespPriority_S), .PIRespRouteId_S(PIRespRouteId_S)
    );

    always #5 CLK = ~CLK;

    function automatic reqVec_t mkReq(input logic [7:0] cntl, input logic [31:0] adrs,
                                      input logic [63:0] data, input logic [7:0] be,
                                      input logic [5:0] id, input logic [1:0] prio,
                                      input logic [11:0] attr, input logic [0:0] routeId);
        return '{cntl: cntl, adrs: adrs, data: data, be: be, id: id, prio: prio,
                 attr: attr, routeId: routeId};
    endfunction

    function automatic respVec_t mkResp(input logic [7:0] cntl, input logic [63:0] data,
                                        input logic [5:0] id, input logic [1:0] prio,
                                        input logic [0:0] routeId);
        return '{cntl: cntl, data: data, id: id, prio: prio, routeId: routeId};
    endfunction

    function automatic reqVec_t sampleReq();
        return '{cntl: POReqCntl_S, adrs: POReqAdrs_S, data: POReqData_S, be: POReqDataBE_S,
                 id: POReqId_S, prio: POReqPriority_S, attr: POReqAttribute_S,
                 routeId: POReqRouteId_S};
    endfunction

    function automatic respVec_t sampleResp();
        return '{cntl: PIRespCntl_M, data: PIRespData_M, id: PIRespId_M,
                 prio: PIRespPriority_M, routeId: PIRespRouteId_M};
    endfunction

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic driveReq(input reqVec_t b);
        POReqValid_M     = 1'b1;
        POReqCntl_M      = b.cntl;
        POReqAdrs_M      = b.adrs;
        POReqData_M      = b.data;
        POReqDataBE_M    = b.be;
        POReqId_M        = b.id;
        POReqPriority_M  = b.prio;
        POReqAttribute_M = b.attr;
        POReqRouteId_M   = b.routeId;
    endtask

    // Waits for the master-side handshake; returns one clock after acceptance plus #1.
    task automatic awaitReq(input reqVec_t b, output int stalls);
        bit done = 1'b0;
        stalls = 0;
        while (!done && stalls <= BUDGET) begin
            @(negedge CLK);
            if (PIReqRdy_M) done = 1'b1;
            else stalls++;
        end
        @(posedge CLK);
        if (done) begin
            reqQ.push_back(b);
        end else begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL reqTimeout: PIReqRdy_M stayed %0b, expected 1 within %0d cycles",
                     PIReqRdy_M, BUDGET);
        end
        #1;
        POReqValid_M = 1'b0;
    endtask

    task automatic sendReq(input reqVec_t b);
        int stalls;
        driveReq(b);
        awaitReq(b, stalls);
    endtask

    task automatic sendResp(input respVec_t b);
        bit done  = 1'b0;
        int waits = 0;
        PIRespValid_S    = 1'b1;
        PIRespCntl_S     = b.cntl;
        PIRespData_S     = b.data;
        PIRespId_S       = b.id;
        PIRespPriority_S = b.prio;
        PIRespRouteId_S  = b.routeId;
        while (!done && waits <= BUDGET) begin
            @(negedge CLK);
            if (PORespRdy_S) done = 1'b1;
            else waits++;
        end
        @(posedge CLK);
        if (done) begin
            respQ.push_back(b);
        end else begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL respTimeout: PORespRdy_S stayed %0b, expected 1 within %0d cycles",
                     PORespRdy_S, BUDGET);
        end
        #1;
        PIRespValid_S = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    // Slave-side request monitor: every delivered beat must match the head of the request scoreboard.
    always @(negedge CLK) begin
        if (POReqValid_S && PIReqRdy_S) begin
            if (reqQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL reqUnexpected: got beat %0h, expected none", sampleReq());
            end else begin
                checkOutput("reqBeat", sampleReq(), reqQ.pop_front());
            end
        end
    end

    // Master-side response monitor: every delivered beat must match the head of the response scoreboard.
    always @(negedge CLK) begin
        if (PIRespValid_M && PORespRdy_M) begin
            if (respQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL respUnexpected: got beat %0h, expected none", sampleResp());
            end else begin
                checkOutput("respBeat", sampleResp(), respQ.pop_front());
            end
        end
    end

    task automatic applyStimulus();
        int      stalls;
        reqVec_t b;

        // Reset behaviour and the one-cycle ready delay after release.
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rstReqValidS", POReqValid_S, 1'b0);
        checkOutput("rstRespValidM", PIRespValid_M, 1'b0);
        checkOutput("rstReqRdyM", PIReqRdy_M, 1'b0);
        checkOutput("rstRespRdyS", PORespRdy_S, 1'b0);
        checkOutput("rstAdrsS", POReqAdrs_S, 32'h0);
        checkOutput("rstRespDataM", PIRespData_M, 64'h0);
        nextCycle();
        RESET_N = 1'b1;
        @(negedge CLK);
        checkOutput("rdyBeforeFirstEdge", PIReqRdy_M, 1'b0);
        @(negedge CLK);
        checkOutput("rdyAfterRelease", PIReqRdy_M, 1'b1);
        checkOutput("respRdyAfterRelease", PORespRdy_S, 1'b1);
        nextCycle();

        // Single read round trip.
        PIReqRdy_S  = 1'b1;
        PORespRdy_M = 1'b1;
        sendReq(mkReq(8'h01, 32'h6000_0010, 64'h0, 8'hFF, 6'd5, 2'd0, 12'h000, 1'b0));
        @(negedge CLK);
        checkOutput("readLatency", POReqValid_S, 1'b1);
        checkOutput("readOutCnt", dut.outCnt, 2'd1);
        nextCycle();
        sendResp(mkResp(8'h01, 64'hDEAD_BEEF_0123_4567, 6'd5, 2'd1, 1'b1));
        @(negedge CLK);
        checkOutput("respLatency", PIRespValid_M, 1'b1);
        nextCycle();
        checkOutput("readOutCntEnd", dut.outCnt, 2'd0);

        // Backpressure: fill the request FIFO, then drain on consecutive cycles.
        PIReqRdy_S = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = mkReq(8'h00, 32'h0000_0100 + 32'(i), 64'h1111_2222_3333_4440 + 64'(i), 8'hF0,
                      6'(i + 1), 2'(i), 12'h100 + 12'(i), 1'(i));
            sendReq(b);
        end
        @(negedge CLK);
        checkOutput("fullBlocksMaster", PIReqRdy_M, 1'b0);
        checkOutput("fullValidS", POReqValid_S, 1'b1);
        nextCycle();
        PIReqRdy_S = 1'b1;
        repeat (4) nextCycle();
        checkOutput("backpressureDrain", reqQ.size(), 0);
        @(negedge CLK);
        checkOutput("drainEmpty", POReqValid_S, 1'b0);
        nextCycle();

        // Outstanding limit of two transactions.
        sendReq(mkReq(8'h01, 32'h6000_0100, 64'h0, 8'hFF, 6'd10, 2'd0, 12'h000, 1'b0));
        sendReq(mkReq(8'h01, 32'h6000_0200, 64'h0, 8'hFF, 6'd11, 2'd0, 12'h000, 1'b0));
        b = mkReq(8'h01, 32'h6000_0300, 64'h0, 8'hFF, 6'd12, 2'd2, 12'h010, 1'b1);
        driveReq(b);
        @(negedge CLK);
        checkOutput("limitBlock1", PIReqRdy_M, 1'b0);
        nextCycle();
        @(negedge CLK);
        checkOutput("limitBlock2", PIReqRdy_M, 1'b0);
        nextCycle();
        sendResp(mkResp(8'h01, 64'h0000_0000_0000_00AA, 6'd10, 2'd0, 1'b0));
        awaitReq(b, stalls);
        checkOutput("limitReleaseLatency", stalls, 1);
        checkOutput("limitOutCnt", dut.outCnt, 2'd2);

        // Simultaneous last request and last response leave the count unchanged.
        sendResp(mkResp(8'h01, 64'h0000_0000_0000_00BB, 6'd11, 2'd0, 1'b0));
        nextCycle();
        checkOutput("afterResp11", dut.outCnt, 2'd1);
        PORespRdy_M = 1'b0;
        sendResp(mkResp(8'h01, 64'h0000_0000_0000_00CC, 6'd12, 2'd3, 1'b1));
        b = mkReq(8'h01, 32'h6000_0400, 64'h0, 8'hFF, 6'd13, 2'd1, 12'h020, 1'b0);
        driveReq(b);
        PORespRdy_M = 1'b1;
        awaitReq(b, stalls);
        checkOutput("simulIncDec", dut.outCnt, 2'd1);

        // Four-beat write: only the last beat counts.
        for (int k = 0; k < 4; k++) begin
            b = mkReq((k == 3) ? 8'h01 : 8'h00, 32'h7000_0000 + 32'(8 * k),
                      64'hC0DE_0000_0000_0000 + 64'(k), 8'hFF, 6'd14, 2'd3, 12'h0A5, 1'b0);
            sendReq(b);
            if (k == 2) checkOutput("burstMidCount", dut.outCnt, 2'd1);
        end
        checkOutput("burstLastCount", dut.outCnt, 2'd2);
        sendResp(mkResp(8'h01, 64'h0000_0000_0000_00DD, 6'd13, 2'd0, 1'b0));
        sendResp(mkResp(8'h01, 64'h0000_0000_0000_00EE, 6'd14, 2'd2, 1'b1));
        nextCycle();
        checkOutput("drainCount", dut.outCnt, 2'd0);

        // Reset in the middle of a burst drops everything in flight.
        PIReqRdy_S  = 1'b0;
        PORespRdy_M = 1'b0;
        sendReq(mkReq(8'h01, 32'h6000_0500, 64'h0, 8'hFF, 6'd20, 2'd0, 12'h000, 1'b0));
        sendResp(mkResp(8'h00, 64'h0000_0000_0000_0055, 6'd21, 2'd0, 1'b0));
        sendReq(mkReq(8'h00, 32'h8000_0000, 64'h0102_0304_0506_0708, 8'hFF, 6'd22, 2'd1, 12'h0, 1'b0));
        sendReq(mkReq(8'h00, 32'h8000_0008, 64'h1112_1314_1516_1718, 8'hFF, 6'd22, 2'd1, 12'h0, 1'b0));
        checkOutput("preResetCount", dut.outCnt, 2'd1);
        #2;
        RESET_N = 1'b0;
        reqQ.delete();
        respQ.delete();
        #1;
        checkOutput("resetDropsReqValid", POReqValid_S, 1'b0);
        checkOutput("resetDropsRespValid", PIRespValid_M, 1'b0);
        checkOutput("resetDropsReqRdy", PIReqRdy_M, 1'b0);
        repeat (2) nextCycle();
        RESET_N     = 1'b1;
        PIReqRdy_S  = 1'b1;
        PORespRdy_M = 1'b1;
        repeat (2) nextCycle();
        checkOutput("postResetReqValid", POReqValid_S, 1'b0);
        checkOutput("postResetRespValid", PIRespValid_M, 1'b0);
        checkOutput("postResetCount", dut.outCnt, 2'd0);
        checkOutput("postResetRdy", PIReqRdy_M, 1'b1);
        checkOutput("postResetAdrs", POReqAdrs_S, 32'h0);

        // A last response with nothing outstanding saturates at zero and flags once.
        sendResp(mkResp(8'h01, 64'h0000_0000_0000_0077, 6'd30, 2'd0, 1'b0));
        nextCycle();
        checkOutput("underflowFlag", dut.underflowPulse, 1'b1);
        checkOutput("underflowCount", dut.outCnt, 2'd0);
        nextCycle();
        checkOutput("underflowPulseEnds", dut.underflowPulse, 1'b0);

        repeat (2) nextCycle();
        checkOutput("reqScoreboardEmpty", reqQ.size(), 0);
        checkOutput("respScoreboardEmpty", respQ.size(), 0);
    endtask

    initial begin
        RESET_N          = 1'b0;
        POReqValid_M     = 1'b0;
        POReqCntl_M      = '0;
        POReqAdrs_M      = '0;
        POReqData_M      = '0;
        POReqDataBE_M    = '0;
        POReqId_M        = '0;
        POReqPriority_M  = '0;
        POReqAttribute_M = '0;
        POReqRouteId_M   = '0;
        PORespRdy_M      = 1'b0;
        PIReqRdy_S       = 1'b0;
        PIRespValid_S    = 1'b0;
        PIRespCntl_S     = '0;
        PIRespData_S     = '0;
        PIRespId_S       = '0;
        PIRespPriority_S = '0;
        PIRespRouteId_S  = '0;
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: still running at %0t, expected to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
